// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage: one entry, one bus request, load align/extend
module mem_access_stage #(
   parameter int XLEN = 64,
   parameter int SB_W = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   input  logic            in_memread,
   input  logic            in_memwrite,
   input  logic [1:0]      in_msize,
   input  logic            in_unsigned,
   input  logic [SB_W-1:0] in_sb,
   output logic            dreq_valid,
   output logic [XLEN-1:0] dreq_addr,
   output logic [1:0]      dreq_size,
   output logic [7:0]      dreq_strobe,
   output logic [XLEN-1:0] dreq_wdata,
   input  logic            dresp_ok,
   input  logic [XLEN-1:0] dresp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_addr,
   output logic [XLEN-1:0] out_mem_data,
   output logic            out_misaligned,
   output logic [SB_W-1:0] out_sb
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t          state;
   logic            is_load_q;
   logic            uns_q;
   logic            mem_op;
   logic            misaligned;
   logic            take;
   logic [2:0]      lo;
   logic [7:0]      size_mask;
   logic [XLEN-1:0] rsh;
   logic [XLEN-1:0] load_ext;

   assign in_ready = resetn && ((state == IDLE) || ((state == HOLD) && out_ready));
   assign take     = in_valid && in_ready;
   assign mem_op   = in_memread || in_memwrite;
   assign lo       = in_addr[2:0];

   always_comb begin
      misaligned = 1'b0;
      size_mask  = 8'h01;
      case (in_msize)
         2'd0: begin misaligned = 1'b0;          size_mask = 8'h01; end
         2'd1: begin misaligned = lo[0];         size_mask = 8'h03; end
         2'd2: begin misaligned = |lo[1:0];      size_mask = 8'h0F; end
         default: begin misaligned = |lo;        size_mask = 8'hFF; end
      endcase
   end

   // Extraction works on the captured request, so the response needs no extra state.
   assign rsh = dresp_data >> {dreq_addr[2:0], 3'b000};

   always_comb begin
      load_ext = rsh;
      case (dreq_size)
         2'd0: load_ext = {{(XLEN-8){rsh[7] & ~uns_q}}, rsh[7:0]};
         2'd1: load_ext = {{(XLEN-16){rsh[15] & ~uns_q}}, rsh[15:0]};
         2'd2: load_ext = {{(XLEN-32){rsh[31] & ~uns_q}}, rsh[31:0]};
         default: load_ext = rsh;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         is_load_q      <= 1'b0;
         uns_q          <= 1'b0;
         dreq_valid     <= 1'b0;
         dreq_addr      <= '0;
         dreq_size      <= 2'd0;
         dreq_strobe    <= 8'h00;
         dreq_wdata     <= '0;
         out_valid      <= 1'b0;
         out_addr       <= '0;
         out_mem_data   <= '0;
         out_misaligned <= 1'b0;
         out_sb         <= '0;
      end else if (take) begin
         out_addr     <= in_addr;
         out_sb       <= in_sb;
         out_mem_data <= '0;
         is_load_q    <= in_memread;
         uns_q        <= in_unsigned;
         if (mem_op && !misaligned) begin
            state          <= REQ;
            dreq_valid     <= 1'b1;
            dreq_addr      <= in_addr;
            dreq_size      <= in_msize;
            dreq_strobe    <= in_memwrite ? (size_mask << lo) : 8'h00;
            dreq_wdata     <= in_wdata << {lo, 3'b000};
            out_valid      <= 1'b0;
            out_misaligned <= 1'b0;
         end else begin
            // Non-memory ops and misaligned accesses skip the bus entirely.
            state          <= HOLD;
            out_valid      <= 1'b1;
            out_misaligned <= mem_op;
         end
      end else begin
         case (state)
            REQ: begin
               if (dresp_ok) begin
                  state        <= HOLD;
                  dreq_valid   <= 1'b0;
                  out_valid    <= 1'b1;
                  out_mem_data <= is_load_q ? load_ext : '0;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
